encoder_homing_ctrl: RTL and testbench
======================================

ENCODER_HOMING_CTRL -- requirements
Module: encoder_homing_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of encoder count and range value.
REQ-002 Parameter STALL_CYCLES, default 1000000: consecutive unchanged-count cycles that declare an end stop.
REQ-003 Parameter TIMEOUT_CYCLES, default 200000000: maximum cycles allowed in one seek phase.
REQ-004 Parameter SETTLE_CYCLES, default 1000: motor-off dwell after zeroing.
REQ-005 clk  in  1  single clock; all logic is clocked on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  level; begins a homing sequence when sampled high in IDLE or ERROR.
REQ-008 abort  in  1  level; cancels any active sequence.
REQ-009 cnt_in  in  DATA_WIDTH  count from the quadrature decoder.
REQ-010 dec_rst  out  1  reset pulse to the quadrature decoder counter.
REQ-011 motor_en  out  1  motor drive enable.
REQ-012 motor_dir  out  1  0 = negative direction, 1 = positive direction.
REQ-013 busy  out  1  high in every state except IDLE and ERROR.
REQ-014 done  out  1  one-cycle pulse on successful completion.
REQ-015 error  out  1  high while in ERROR.
REQ-016 range_out  out  DATA_WIDTH  travel span captured by the last successful sequence.

Function
REQ-017 The controller SHALL use the states IDLE, SEEK_NEG, ZERO, SETTLE, SEEK_POS, CAPTURE, DONE and ERROR; all outputs SHALL be registered.
REQ-018 In IDLE or ERROR, start=1 and abort=0 SHALL move the FSM to SEEK_NEG on the next edge; start SHALL be ignored in all other states.
REQ-019 In SEEK_NEG: motor_en=1, motor_dir=0; in SEEK_POS: motor_en=1, motor_dir=1; in all other states: motor_en=0.
REQ-020 Stall counter: every seek cycle, it SHALL compare cnt_in with cnt_in registered one cycle earlier; if equal, increment (saturating); if different, clear.
REQ-021 A stall SHALL be detected in the cycle the stall counter reaches STALL_CYCLES.
REQ-022 Timeout counter: it SHALL increment every seek cycle; reaching TIMEOUT_CYCLES SHALL move the FSM to ERROR.
REQ-023 On entry to either seek state, both the stall and timeout counters SHALL be cleared, and the previous-count register SHALL be loaded with cnt_in.
REQ-024 A stall in SEEK_NEG SHALL move the FSM to ZERO.
REQ-025 ZERO SHALL last exactly one cycle, with dec_rst=1 only during that cycle, and then move to SETTLE.
REQ-026 SETTLE SHALL last SETTLE_CYCLES cycles and then move to SEEK_POS.
REQ-027 A stall in SEEK_POS SHALL move the FSM to CAPTURE.
REQ-028 CAPTURE SHALL load range_out with cnt_in, unsigned with no truncation, and then move to DONE.
REQ-029 DONE SHALL drive done=1 for exactly one cycle and then move to IDLE.
REQ-030 If stall and timeout occur in the same cycle, the stall SHALL take priority.
REQ-031 abort=1 in any busy state SHALL move the FSM to IDLE on the next edge, with motor_en=0, no done pulse, and range_out unchanged.
REQ-032 abort SHALL take priority over start, stall and timeout.
REQ-033 If abort=1 and start=1 together in IDLE or ERROR, the FSM SHALL stay in its current state.
REQ-034 ERROR SHALL hold error=1 and motor_en=0 until a valid start or rst; range_out SHALL be unchanged.

Reset
REQ-035 rst SHALL take priority over all inputs.
REQ-036 On rst, the FSM SHALL go to IDLE with dec_rst=0, motor_en=0, motor_dir=0, busy=0, done=0, error=0 and range_out=0, and with all counters cleared.
REQ-037 rst asserted mid-sequence SHALL stop the motor on the following edge.

Verification (STALL_CYCLES=4, TIMEOUT_CYCLES=100, SETTLE_CYCLES=2)
REQ-038 Nominal: cnt_in moves during the negative seek and then freezes; the bench then ramps it 0->500 and freezes -> one dec_rst pulse, motor_dir 0 then 1, range_out=500, one done pulse, busy low afterwards.
REQ-039 Timeout: cnt_in toggles every cycle in SEEK_NEG -> ERROR after 100 cycles, error=1, motor_en=0; a following start restarts the sequence and clears error.
REQ-040 Stall coincident with timeout: cnt_in changes for 96 seek cycles and is then held, so the stall is reached at cycle 100 -> ZERO is entered, not ERROR.
REQ-041 Abort in SEEK_POS -> IDLE next edge, motor_en=0, done never pulses, range_out keeps its previous value.
REQ-042 Start+abort together in IDLE -> no state change; rst during SETTLE -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/encoder_homing_ctrl.sv
// Homing sequencer: drives to the negative end stop, zeroes the decoder, settles,
// then drives to the positive end stop and captures the travel span.
module encoder_homing_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int STALL_CYCLES   = 1000000,
   parameter int TIMEOUT_CYCLES = 200000000,
   parameter int SETTLE_CYCLES  = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] cnt_in,
   output logic                  dec_rst,
   output logic                  motor_en,
   output logic                  motor_dir,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [DATA_WIDTH-1:0] range_out
);

   localparam int STALL_W     = (STALL_CYCLES   < 2) ? 1 : $clog2(STALL_CYCLES + 1);
   localparam int TMO_W       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int SETTLE_W    = (SETTLE_CYCLES  < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam int SETTLE_LAST = (SETTLE_CYCLES  > 0) ? SETTLE_CYCLES - 1 : 0;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SEEK_NEG = 3'd1,
      ZERO     = 3'd2,
      SETTLE   = 3'd3,
      SEEK_POS = 3'd4,
      CAPTURE  = 3'd5,
      DONE     = 3'd6,
      ERROR    = 3'd7
   } state_t;

   state_t                state_q, state_d;
   logic [STALL_W-1:0]    stall_q, stall_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic [SETTLE_W-1:0]   settle_q, settle_d;
   logic [DATA_WIDTH-1:0] prev_q, prev_d;
   logic [DATA_WIDTH-1:0] range_q, range_d;
   logic                  dec_rst_q, dec_rst_d;
   logic                  motor_en_q, motor_en_d;
   logic                  motor_dir_q, motor_dir_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  in_seek, stall_hit, tmo_hit, active;

   always_comb begin
      state_d   = state_q;
      stall_d   = stall_q;
      tmo_d     = tmo_q;
      settle_d  = settle_q;
      prev_d    = prev_q;
      range_d   = range_q;
      stall_hit = 1'b0;
      tmo_hit   = 1'b0;
      in_seek   = (state_q == SEEK_NEG) || (state_q == SEEK_POS);
      active    = (state_q != IDLE) && (state_q != ERROR);

      if (in_seek) begin
         prev_d = cnt_in;
         if (cnt_in == prev_q) begin
            stall_d = (stall_q == STALL_W'(STALL_CYCLES)) ? stall_q : stall_q + 1'b1;
         end else begin
            stall_d = '0;
         end
         tmo_d     = (tmo_q == TMO_W'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + 1'b1;
         stall_hit = (stall_d == STALL_W'(STALL_CYCLES));
         tmo_hit   = (tmo_d == TMO_W'(TIMEOUT_CYCLES));
      end

      case (state_q)
         IDLE, ERROR: if (start && !abort) state_d = SEEK_NEG;
         SEEK_NEG: begin
            // Stall wins over a coincident timeout.
            if (stall_hit)    state_d = ZERO;
            else if (tmo_hit) state_d = ERROR;
         end
         ZERO:     state_d = SETTLE;
         SETTLE: begin
            if (settle_q >= SETTLE_W'(SETTLE_LAST)) state_d = SEEK_POS;
            else                                    settle_d = settle_q + 1'b1;
         end
         SEEK_POS: begin
            if (stall_hit)    state_d = CAPTURE;
            else if (tmo_hit) state_d = ERROR;
         end
         CAPTURE: begin
            range_d = cnt_in;
            state_d = DONE;
         end
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase

      if (abort && active) begin
         state_d = IDLE;
         range_d = range_q;
      end

      // Each seek phase starts with fresh counters and a fresh reference count.
      if (((state_d == SEEK_NEG) || (state_d == SEEK_POS)) && (state_d != state_q)) begin
         stall_d = '0;
         tmo_d   = '0;
         prev_d  = cnt_in;
      end
      if (state_d != SETTLE) settle_d = '0;

      dec_rst_d   = (state_d == ZERO);
      motor_en_d  = (state_d == SEEK_NEG) || (state_d == SEEK_POS);
      motor_dir_d = (state_d == SEEK_POS);
      busy_d      = (state_d != IDLE) && (state_d != ERROR);
      done_d      = (state_d == DONE);
      error_d     = (state_d == ERROR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         stall_q     <= '0;
         tmo_q       <= '0;
         settle_q    <= '0;
         prev_q      <= '0;
         range_q     <= '0;
         dec_rst_q   <= 1'b0;
         motor_en_q  <= 1'b0;
         motor_dir_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_q     <= stall_d;
         tmo_q       <= tmo_d;
         settle_q    <= settle_d;
         prev_q      <= prev_d;
         range_q     <= range_d;
         dec_rst_q   <= dec_rst_d;
         motor_en_q  <= motor_en_d;
         motor_dir_q <= motor_dir_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign dec_rst   = dec_rst_q;
   assign motor_en  = motor_en_q;
   assign motor_dir = motor_dir_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign range_out = range_q;

endmodule

// File: tb/tb_encoder_homing_ctrl.sv
// Directed bench for encoder_homing_ctrl with short stall/timeout/settle windows.
module tb_encoder_homing_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [31:0] cnt_in;
   logic        dec_rst, motor_en, motor_dir, busy, done, error;
   logic [31:0] range_out;
   int          n_assert = 0;
   int          n_fail   = 0;

   encoder_homing_ctrl #(
      .DATA_WIDTH(32), .STALL_CYCLES(4), .TIMEOUT_CYCLES(100), .SETTLE_CYCLES(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .cnt_in(cnt_in),
      .dec_rst(dec_rst), .motor_en(motor_en), .motor_dir(motor_dir),
      .busy(busy), .done(done), .error(error), .range_out(range_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Flag order: {dec_rst, motor_en, motor_dir, busy, done, error}
   task automatic chk_o(input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      obs = {dec_rst, motor_en, motor_dir, busy, done, error};
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: flags observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_r(input string tag, input logic [31:0] exp);
      n_assert++;
      assert (range_out === exp) else begin
         n_fail++;
         $error("FAIL %s: range_out observed %0d expected %0d", tag, range_out, exp);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; cnt_in = 32'd0;
      step(); step();
      chk_o("reset_flags", 6'b000000);
      chk_r("reset_range", 32'd0);
      rst = 1'b0;
      step();
      chk_o("idle", 6'b000000);

      // start together with abort in IDLE is ignored
      start = 1'b1; abort = 1'b1;
      step();
      chk_o("start_abort_idle", 6'b000000);
      start = 1'b0; abort = 1'b0;

      // Nominal sequence
      cnt_in = 32'd10; start = 1'b1;
      step();
      start = 1'b0;
      chk_o("neg_entry", 6'b010100);
      for (int i = 0; i < 5; i++) begin
         cnt_in = cnt_in - 32'd1;
         step();
         chk_o("neg_moving", 6'b010100);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         chk_o("neg_frozen", 6'b010100);
      end
      step();
      chk_o("zero", 6'b100100);
      cnt_in = 32'd0;
      step();
      chk_o("settle1", 6'b000100);
      step();
      chk_o("settle2", 6'b000100);
      step();
      chk_o("pos_entry", 6'b011100);
      for (int i = 0; i < 5; i++) begin
         cnt_in = cnt_in + 32'd100;
         step();
         chk_o("pos_moving", 6'b011100);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         chk_o("pos_frozen", 6'b011100);
      end
      step();
      chk_o("capture", 6'b000100);
      chk_r("capture_range", 32'd0);
      step();
      chk_o("done", 6'b000110);
      chk_r("done_range", 32'd500);
      step();
      chk_o("idle_after_done", 6'b000000);
      chk_r("idle_range", 32'd500);

      // Abort during the positive seek
      start = 1'b1;
      step();
      start = 1'b0;
      chk_o("abort_neg_entry", 6'b010100);
      for (int i = 0; i < 3; i++) step();
      step();
      chk_o("abort_zero", 6'b100100);
      cnt_in = 32'd0;
      for (int i = 0; i < 3; i++) step();
      chk_o("abort_pos_entry", 6'b011100);
      cnt_in = 32'd7;
      step();
      chk_o("abort_pos_moving", 6'b011100);
      abort = 1'b1;
      step();
      chk_o("abort_idle", 6'b000000);
      chk_r("abort_range", 32'd500);
      abort = 1'b0;
      step();
      chk_o("abort_no_done", 6'b000000);

      // Timeout: count keeps toggling in the negative seek
      cnt_in = 32'd0; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 99; i++) begin
         cnt_in = cnt_in ^ 32'd1;
         step();
      end
      chk_o("tmo_cycle99", 6'b010100);
      cnt_in = cnt_in ^ 32'd1;
      step();
      chk_o("tmo_error", 6'b000001);
      chk_r("tmo_range", 32'd500);
      start = 1'b1; abort = 1'b1;
      step();
      chk_o("start_abort_error", 6'b000001);
      abort = 1'b0;
      step();
      start = 1'b0;
      chk_o("error_restart", 6'b010100);
      rst = 1'b1;
      step();
      chk_o("rst_in_seek", 6'b000000);
      chk_r("rst_in_seek_range", 32'd0);
      rst = 1'b0;
      step();

      // Stall coincident with timeout at seek cycle 100
      cnt_in = 32'd0; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 96; i++) begin
         cnt_in = cnt_in + 32'd1;
         step();
      end
      for (int i = 0; i < 3; i++) begin
         step();
         chk_o("coinc_holding", 6'b010100);
      end
      step();
      chk_o("coinc_zero", 6'b100100);
      cnt_in = 32'd0;
      step();
      chk_o("coinc_settle", 6'b000100);

      // Reset during SETTLE
      rst = 1'b1;
      step();
      chk_o("rst_settle_flags", 6'b000000);
      chk_r("rst_settle_range", 32'd0);
      rst = 1'b0;
      step();
      chk_o("idle_final", 6'b000000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
